// File: rtl/circuit1_pkg.sv
// Shared width helpers and the z tie-break rule for the circuit1 pipelined datapath.
package circuit1_pkg;

  // When set, z = (d > e) ? d : e, so equal sums select e.
  localparam bit Z_TIE_SEL_E = 1'b1;

  function automatic int sum_w(input int w);
    return w + 1;
  endfunction

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/circuit1_pipe_reg.sv
// One elastic register stage: accepts when empty or when its consumer takes the held item.
module pipe_reg #(
  parameter int DW = 8
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] din,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dout
);

  logic          valid_q;
  logic          valid_d;
  logic [DW-1:0] data_q;
  logic [DW-1:0] data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign dout      = data_q;

  // An empty predecessor loads a bubble; payload only moves with a real item.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = din;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/circuit1_pipe.sv
// Two-stage pipelined Circuit1: d=a+b, e=a+c, f=a*c; then z=max(d,e), x=f-d, borrow, result count.
module circuit1_pipe
  import circuit1_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH:0]       z,
  output logic [2*WIDTH-1:0]   x,
  output logic                 borrow,
  output logic [CNT_W-1:0]     out_count
);

  localparam int SW   = sum_w(WIDTH);
  localparam int PW   = prod_w(WIDTH);
  localparam int S1_W = 2 * SW + PW;
  localparam int S2_W = PW + SW + 1;

  logic [SW-1:0]    d_in;
  logic [SW-1:0]    e_in;
  logic [PW-1:0]    f_in;
  logic [S1_W-1:0]  s1_din;
  logic [S1_W-1:0]  s1_dout;
  logic             s1_valid;
  logic             s2_ready;

  logic [SW-1:0]    d_s1;
  logic [SW-1:0]    e_s1;
  logic [PW-1:0]    f_s1;
  logic             d_wins;
  logic [SW-1:0]    z_in;
  logic [PW-1:0]    x_in;
  logic             borrow_in;
  logic [S2_W-1:0]  s2_din;
  logic [S2_W-1:0]  s2_dout;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign d_in   = SW'(a) + SW'(b);
  assign e_in   = SW'(a) + SW'(c);
  assign f_in   = PW'(a) * PW'(c);
  assign s1_din = {d_in, e_in, f_in};

  pipe_reg #(.DW(S1_W)) u_stage1 (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (s1_din),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .dout      (s1_dout)
  );

  assign d_s1 = s1_dout[S1_W-1 -: SW];
  assign e_s1 = s1_dout[PW +: SW];
  assign f_s1 = s1_dout[PW-1:0];

  // x wraps modulo 2^PW; borrow records that the subtraction went below zero.
  assign d_wins    = Z_TIE_SEL_E ? (d_s1 > e_s1) : (d_s1 >= e_s1);
  assign z_in      = d_wins ? d_s1 : e_s1;
  assign x_in      = f_s1 - PW'(d_s1);
  assign borrow_in = f_s1 < PW'(d_s1);
  assign s2_din    = {x_in, z_in, borrow_in};

  pipe_reg #(.DW(S2_W)) u_stage2 (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .din       (s2_din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (s2_dout)
  );

  assign x      = s2_dout[S2_W-1 -: PW];
  assign z      = s2_dout[1 +: SW];
  assign borrow = s2_dout[0];

  always_comb begin
    count_d = count_q;
    if (out_valid && out_ready) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out_count = count_q;

endmodule
